micro_datapath: RTL and testbench

//  Execution datapath driven by the microprogram sequencer's 17-bit control word.

---
 rtl/micro_pkg.sv | 34 +++
 rtl/micro_alu.sv | 39 +++
 rtl/micro_datapath.sv | 98 +++++++++
 tb/tb_micro_datapath.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/micro_pkg.sv
// Shared definitions for the microprogrammed datapath and its microcode assembler:
// control-word layout and ALU opcodes.
package micro_pkg;

    localparam int CW_W = 17;

    localparam int F_IN_LD  = 16;
    localparam int F_OUT_EN = 15;
    localparam int F_OP_HI  = 14;
    localparam int F_OP_LO  = 12;
    localparam int F_WR_EN  = 11;
    localparam int F_FLG_EN = 10;
    localparam int F_DST_HI = 9;
    localparam int F_DST_LO = 8;
    localparam int F_SA_HI  = 7;
    localparam int F_SA_LO  = 6;
    localparam int F_SB_HI  = 5;
    localparam int F_SB_LO  = 4;
    localparam int F_USE_IMM = 3;
    localparam int F_IMM_HI = 2;
    localparam int F_IMM_LO = 0;

    typedef enum logic [2:0] {
        ALU_PASS = 3'b000,
        ALU_ADD  = 3'b001,
        ALU_SUB  = 3'b010,
        ALU_AND  = 3'b011,
        ALU_OR   = 3'b100,
        ALU_XOR  = 3'b101,
        ALU_SHL  = 3'b110,
        ALU_SHR  = 3'b111
    } alu_op_e;

endpackage

// File: rtl/micro_alu.sv
// Combinational ALU: result is mod 2^WIDTH; carry is carry-out, borrow, or the
// bit shifted out, and zero for pass/logic operations.
module micro_alu
    import micro_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  alu_op_e          op,
    output logic [WIDTH-1:0] result,
    output logic             carry
);

    always_comb begin
        result = a;
        carry  = 1'b0;
        case (op)
            ALU_PASS: result = a;
            ALU_ADD:  {carry, result} = {1'b0, a} + {1'b0, b};
            ALU_SUB: begin
                result = a - b;
                carry  = (a < b);
            end
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_XOR:  result = a ^ b;
            ALU_SHL: begin
                result = {a[WIDTH-2:0], 1'b0};
                carry  = a[WIDTH-1];
            end
            ALU_SHR: begin
                result = {1'b0, a[WIDTH-1:1]};
                carry  = a[0];
            end
        endcase
    end

endmodule

// File: rtl/micro_datapath.sv
// Datapath executing one control word per cycle: 4-entry register file, ALU,
// Carry/Zero flags and a registered byte output with a one-cycle valid pulse.
module micro_datapath
    import micro_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CW_W-1:0]  ControlBus,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             out_valid,
    output logic             CarryFlag,
    output logic             ZeroFlag
);

    logic             in_ld, out_en, wr_en, flg_en, use_imm;
    logic [1:0]       dst, src_a, src_b;
    logic [2:0]       imm;
    alu_op_e          alu_op;

    assign in_ld   = ControlBus[F_IN_LD];
    assign out_en  = ControlBus[F_OUT_EN];
    assign alu_op  = alu_op_e'(ControlBus[F_OP_HI:F_OP_LO]);
    assign wr_en   = ControlBus[F_WR_EN];
    assign flg_en  = ControlBus[F_FLG_EN];
    assign dst     = ControlBus[F_DST_HI:F_DST_LO];
    assign src_a   = ControlBus[F_SA_HI:F_SA_LO];
    assign src_b   = ControlBus[F_SB_HI:F_SB_LO];
    assign use_imm = ControlBus[F_USE_IMM];
    assign imm     = ControlBus[F_IMM_HI:F_IMM_LO];

    logic [WIDTH-1:0] regs_q [4];
    logic [WIDTH-1:0] regs_d [4];
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             out_valid_q, out_valid_d;
    logic             carry_q, carry_d, zero_q, zero_d;

    logic [WIDTH-1:0] opnd_a, opnd_b, alu_result;
    logic             alu_carry;

    // Operands always come from the registered file, so reading R[dst] sees the old value.
    assign opnd_a = regs_q[src_a];
    assign opnd_b = use_imm ? {{(WIDTH-3){1'b0}}, imm} : regs_q[src_b];

    micro_alu #(.WIDTH(WIDTH)) u_alu (
        .a      (opnd_a),
        .b      (opnd_b),
        .op     (alu_op),
        .result (alu_result),
        .carry  (alu_carry)
    );

    always_comb begin
        regs_d      = regs_q;
        data_out_d  = data_out_q;
        out_valid_d = out_en;
        carry_d     = carry_q;
        zero_d      = zero_q;
        for (int i = 0; i < 4; i++) begin
            if (dst == 2'(i)) begin
                if (in_ld)
                    regs_d[i] = data_in;
                else if (wr_en)
                    regs_d[i] = alu_result;
            end
        end
        if (out_en)
            data_out_d = opnd_a;
        if (flg_en) begin
            carry_d = alu_carry;
            zero_d  = (alu_result == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            regs_q      <= '{default: '0};
            data_out_q  <= '0;
            out_valid_q <= 1'b0;
            carry_q     <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            regs_q      <= regs_d;
            data_out_q  <= data_out_d;
            out_valid_q <= out_valid_d;
            carry_q     <= carry_d;
            zero_q      <= zero_d;
        end
    end

    assign data_out  = data_out_q;
    assign out_valid = out_valid_q;
    assign CarryFlag = carry_q;
    assign ZeroFlag  = zero_q;

endmodule

// File: tb/tb_micro_datapath.sv
// Bench for micro_datapath: directed scenarios with literal expectations plus
// randomized control words checked every cycle against an arithmetic model.
module tb_micro_datapath;
    import micro_pkg::*;

    localparam int W = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [16:0]   ControlBus = '0;
    logic [W-1:0]  data_in = '0;
    logic [W-1:0]  data_out;
    logic          out_valid, CarryFlag, ZeroFlag;

    int checks = 0;
    int errors = 0;

    // Reference model state: what the outputs must be after the last applied edge.
    int m_regs [4];
    int m_dout, m_valid, m_carry, m_zero;
    bit model_valid = 1'b0;

    micro_datapath #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .ControlBus (ControlBus),
        .data_in    (data_in),
        .data_out   (data_out),
        .out_valid  (out_valid),
        .CarryFlag  (CarryFlag),
        .ZeroFlag   (ZeroFlag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [16:0] mk(input bit ld, input bit oe, input int op, input bit wr,
                                       input bit fl, input int d, input int sa, input int sb,
                                       input bit ui, input int im);
        logic [16:0] cw;
        cw = '0;
        cw[16] = ld; cw[15] = oe; cw[14:12] = 3'(op); cw[11] = wr; cw[10] = fl;
        cw[9:8] = 2'(d); cw[7:6] = 2'(sa); cw[5:4] = 2'(sb); cw[3] = ui; cw[2:0] = 3'(im);
        return cw;
    endfunction

    task automatic model_apply(input bit rst, input logic [16:0] cw, input int din);
        int a, b, res, c, op, d;
        if (rst) begin
            for (int i = 0; i < 4; i++) m_regs[i] = 0;
            m_dout = 0; m_valid = 0; m_carry = 0; m_zero = 0;
            model_valid = 1'b1;
            return;
        end
        op = int'(cw[14:12]);
        d  = int'(cw[9:8]);
        a  = m_regs[int'(cw[7:6])];
        b  = cw[3] ? int'(cw[2:0]) : m_regs[int'(cw[5:4])];
        c  = 0;
        case (op)
            0: res = a;
            1: begin res = (a + b) % 256; c = (a + b > 255) ? 1 : 0; end
            2: begin res = (a - b + 256) % 256; c = (a < b) ? 1 : 0; end
            3: res = a & b;
            4: res = a | b;
            5: res = a ^ b;
            6: begin res = (a * 2) % 256; c = a / 128; end
            default: begin res = a / 2; c = a % 2; end
        endcase
        m_valid = cw[15] ? 1 : 0;
        if (cw[15]) m_dout = a;
        if (cw[10]) begin
            m_carry = c;
            m_zero  = (res == 0) ? 1 : 0;
        end
        if (cw[16]) m_regs[d] = din;
        else if (cw[11]) m_regs[d] = res;
    endtask

    // Apply one control word for one clock edge; returns 1 time unit after the edge.
    task automatic step(input bit rst, input logic [16:0] cw, input logic [W-1:0] din);
        reset = rst; ControlBus = cw; data_in = din;
        @(posedge clk);
        #1;
        model_apply(rst, cw, int'(din));
        $display("txn t=%0t rst=%0b cw=0x%05h din=0x%02h -> dout=0x%02h v=%0b C=%0b Z=%0b",
                 $time, rst, cw, din, data_out, out_valid, CarryFlag, ZeroFlag);
    endtask

    task automatic load(input int d, input int v);
        step(1'b0, mk(1, 0, 0, 0, 0, d, 0, 0, 0, 0), 8'(v));
    endtask

    task automatic show(input int s);
        step(1'b0, mk(0, 1, 0, 0, 0, 0, s, 0, 0, 0), 8'h00);
    endtask

    always @(negedge clk) begin
        if (model_valid) begin
            chk("cyc_data_out",  data_out,  32'(m_dout));
            chk("cyc_out_valid", out_valid, 32'(m_valid));
            chk("cyc_carry",     CarryFlag, 32'(m_carry));
            chk("cyc_zero",      ZeroFlag,  32'(m_zero));
        end
    end

    initial begin
        // Reset with random control words must clear everything.
        for (int i = 0; i < 3; i++) step(1'b1, 17'($urandom), 8'($urandom));
        chk("rst_dout", data_out, 0);  chk("rst_valid", out_valid, 0);
        chk("rst_carry", CarryFlag, 0); chk("rst_zero", ZeroFlag, 0);
        for (int r = 0; r < 4; r++) begin
            show(r);
            chk("rst_reg", data_out, 0);
        end

        // IN/OUT
        load(2, 8'hA5);
        show(2);
        chk("io_dout", data_out, 8'hA5); chk("io_valid", out_valid, 1);
        step(1'b0, '0, 8'h00);
        chk("io_hold_dout", data_out, 8'hA5); chk("io_valid_drop", out_valid, 0);

        // ADD with carry, then ADD immediate wrapping to zero
        load(0, 8'hF0); load(1, 8'h20);
        step(1'b0, mk(0, 0, ALU_ADD, 1, 1, 3, 0, 1, 0, 0), 8'h00);
        chk("add_c", CarryFlag, 1); chk("add_z", ZeroFlag, 0);
        show(3);  chk("add_res", data_out, 8'h10);
        load(0, 8'hFF);
        step(1'b0, mk(0, 0, ALU_ADD, 1, 1, 0, 0, 0, 1, 1), 8'h00);
        chk("addi_c", CarryFlag, 1); chk("addi_z", ZeroFlag, 1);
        show(0);  chk("addi_res", data_out, 8'h00);

        // SUB as compare (no write)
        load(0, 3); load(1, 5);
        step(1'b0, mk(0, 0, ALU_SUB, 0, 1, 0, 0, 1, 0, 0), 8'h00);
        chk("cmp_c", CarryFlag, 1); chk("cmp_z", ZeroFlag, 0);
        show(0);  chk("cmp_keep", data_out, 3);
        load(0, 5);
        step(1'b0, mk(0, 0, ALU_SUB, 0, 1, 0, 0, 1, 0, 0), 8'h00);
        chk("cmpeq_c", CarryFlag, 0); chk("cmpeq_z", ZeroFlag, 1);

        // Shifts and logic
        load(0, 8'h81);
        step(1'b0, mk(0, 0, ALU_SHL, 1, 1, 1, 0, 0, 0, 0), 8'h00);
        chk("shl_c", CarryFlag, 1);
        show(1);  chk("shl_res", data_out, 8'h02);
        step(1'b0, mk(0, 0, ALU_SHR, 1, 1, 1, 0, 0, 0, 0), 8'h00);
        chk("shr_c", CarryFlag, 1);
        show(1);  chk("shr_res", data_out, 8'h40);
        load(0, 8'h0F); load(1, 8'hF0);
        step(1'b0, mk(0, 0, ALU_AND, 1, 1, 2, 0, 1, 0, 0), 8'h00);
        chk("and_c", CarryFlag, 0); chk("and_z", ZeroFlag, 1);

        // NOPs change nothing; the per-cycle compare covers the hold
        for (int i = 0; i < 10; i++) step(1'b0, '0, 8'($urandom));
        chk("nop_z", ZeroFlag, 1);
        show(2);  chk("nop_reg", data_out, 8'h00);

        // in_ld beats wr_en; flags still follow the ALU (0x0F+0xF0=0xFF)
        step(1'b0, mk(1, 0, ALU_ADD, 1, 1, 2, 0, 1, 0, 0), 8'h3C);
        chk("prio_c", CarryFlag, 0); chk("prio_z", ZeroFlag, 0);
        show(2);  chk("prio_reg", data_out, 8'h3C);

        // Randomized traffic with occasional mid-sequence resets
        for (int i = 0; i < 400; i++) begin
            logic [16:0] cw;
            cw = 17'($urandom);
            if ($urandom_range(0, 9) == 0) cw = '0;
            step($urandom_range(0, 39) == 0, cw, 8'($urandom));
        end

        // Explicit mid-sequence reset
        load(1, 8'h77);
        step(1'b1, mk(1, 1, ALU_ADD, 1, 1, 1, 1, 1, 0, 0), 8'h55);
        chk("mid_rst_dout", data_out, 0); chk("mid_rst_c", CarryFlag, 0);
        show(1);  chk("mid_rst_reg", data_out, 0);

        step(1'b0, '0, 8'h00);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
